// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - VGA raster timing: pixel prescaler, h/v counters, syncs, active window
// All outputs decode the position being entered, so they move on the same edge as the counters.
module vga_timing_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clock,
  input  logic             res,
  input  logic             enable,
  output logic             pixelTick,
  output logic             horizontalSync,
  output logic             verticalSync,
  output logic             displayActive,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             lineStart,
  output logic             frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             SYNC_ON  = (SYNC_POL != 0);
  localparam logic             SYNC_OFF = (SYNC_POL == 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             tick_q, tick_d, line_q, line_d, frame_q, frame_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             adv, h_wrap;
  logic [CNT_W-1:0] h_next, v_next;

  always_comb begin
    adv    = enable && (div_q == DIV_LAST);
    div_d  = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    h_wrap = (h_q == H_LAST);
    h_next = h_wrap ? '0 : h_q + CNT_W'(1);
    v_next = v_q;
    if (h_wrap) begin
      v_next = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end

    h_d     = h_q;
    v_d     = v_q;
    x_d     = x_q;
    y_d     = y_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    tick_d  = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;

    // Level outputs only move on adv; strobes fall back to 0 on every other clock.
    if (adv) begin
      h_d     = h_next;
      v_d     = v_next;
      x_d     = h_next;
      y_d     = v_next;
      de_d    = (h_next < H_ACT_C) && (v_next < V_ACT_C);
      hs_d    = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ON : SYNC_OFF;
      vs_d    = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ON : SYNC_OFF;
      tick_d  = 1'b1;
      line_d  = (h_next == '0);
      frame_d = (h_next == '0) && (v_next == '0);
    end
  end

  // Counters park on their last position so the first adv after reset enters (0,0).
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      div_q   <= '0;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= SYNC_OFF;
      vs_q    <= SYNC_OFF;
      tick_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      tick_q  <= tick_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign pixelTick      = tick_q;
  assign horizontalSync = hs_q;
  assign verticalSync   = vs_q;
  assign displayActive  = de_q;
  assign pixelX         = x_q;
  assign pixelY         = y_q;
  assign lineStart      = line_q;
  assign frameStart     = frame_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - self-checking bench for vga_timing_generator (three configurations)
// Instance 0: defaults, 1: shrunk raster, 2: CLK_DIV=1 with active-high syncs.
module tb_vga_timing_generator;

  logic       clk;
  logic       res;
  logic       enable;
  logic       tick[3], hs[3], vs[3], de[3], ls[3], fs[3];
  logic [9:0] px[3], py[3];

  int total = 0;
  int bad   = 0;

  int p_div[3] = '{4, 4, 1};
  int p_ha[3]  = '{640, 8, 640};
  int p_hfp[3] = '{16, 2, 16};
  int p_hs[3]  = '{96, 2, 96};
  int p_hbp[3] = '{48, 2, 48};
  int p_va[3]  = '{480, 4, 480};
  int p_vfp[3] = '{10, 1, 10};
  int p_vs[3]  = '{2, 1, 2};
  int p_vbp[3] = '{33, 1, 33};
  int p_pol[3] = '{0, 0, 1};

  // Model state: enabled clocks since reset, and whether the last edge was a pixel advance.
  int e[3]     = '{0, 0, 0};
  bit adv_m[3] = '{0, 0, 0};

  vga_timing_generator u_def (
    .clock(clk), .res(res), .enable(enable),
    .pixelTick(tick[0]), .horizontalSync(hs[0]), .verticalSync(vs[0]),
    .displayActive(de[0]), .pixelX(px[0]), .pixelY(py[0]),
    .lineStart(ls[0]), .frameStart(fs[0])
  );

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clock(clk), .res(res), .enable(enable),
    .pixelTick(tick[1]), .horizontalSync(hs[1]), .verticalSync(vs[1]),
    .displayActive(de[1]), .pixelX(px[1]), .pixelY(py[1]),
    .lineStart(ls[1]), .frameStart(fs[1])
  );

  vga_timing_generator #(.CLK_DIV(1), .SYNC_POL(1)) u_fast (
    .clock(clk), .res(res), .enable(enable),
    .pixelTick(tick[2]), .horizontalSync(hs[2]), .verticalSync(vs[2]),
    .displayActive(de[2]), .pixelX(px[2]), .pixelY(py[2]),
    .lineStart(ls[2]), .frameStart(fs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge res) begin
    for (int k = 0; k < 3; k++) begin
      if (res) begin
        e[k]     = 0;
        adv_m[k] = 1'b0;
      end else begin
        adv_m[k] = enable && (((e[k] + 1) % p_div[k]) == 0);
        if (enable) e[k] = e[k] + 1;
      end
    end
  end

  function automatic logic [25:0] obs_of(input int k);
    return {tick[k], hs[k], vs[k], de[k], ls[k], fs[k], px[k], py[k]};
  endfunction

  // Position = (advances - 1) folded into the raster; every output is a plain function of it.
  function automatic logic [25:0] exp_of(input int k);
    int   ht, vt, n, p, xx, yy;
    logic pol, t, h, v, d;
    pol = (p_pol[k] != 0);
    ht  = p_ha[k] + p_hfp[k] + p_hs[k] + p_hbp[k];
    vt  = p_va[k] + p_vfp[k] + p_vs[k] + p_vbp[k];
    n   = e[k] / p_div[k];
    if (n == 0) return {1'b0, ~pol, ~pol, 23'd0};
    p  = (n - 1) % (ht * vt);
    xx = p % ht;
    yy = p / ht;
    t  = adv_m[k];
    d  = (xx < p_ha[k]) && (yy < p_va[k]);
    h  = (xx >= p_ha[k] + p_hfp[k] && xx < p_ha[k] + p_hfp[k] + p_hs[k]) ? pol : ~pol;
    v  = (yy >= p_va[k] + p_vfp[k] && yy < p_va[k] + p_vfp[k] + p_vs[k]) ? pol : ~pol;
    return {t, h, v, d, t && (xx == 0), t && (xx == 0) && (yy == 0), 10'(xx), 10'(yy)};
  endfunction

  task automatic test_reset();
    logic [25:0] rv;
    res = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rv = {1'b0, (p_pol[k] == 0), (p_pol[k] == 0), 23'd0};
      total++;
      if (obs_of(k) !== rv) begin
        bad++;
        $display("FAIL reset_state[%0d] got=%h required=%h", k, obs_of(k), rv);
      end
    end
    res = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++;
          $display("FAIL model[%0d] at %0t got=%h required=%h", k, $time, obs_of(k), exp_of(k));
        end
      end
      total++;
      if (tick[0] !== (i == 4)) begin
        bad++;
        $display("FAIL first_tick clk=%0d got=%b required=%b", i, tick[0], (i == 4));
      end
      total++;
      if (tick[2] !== 1'b1) begin
        bad++;
        $display("FAIL fast_tick clk=%0d got=%b required=1", i, tick[2]);
      end
    end
    total++;
    if ({ls[0], fs[0], de[0], px[0], py[0]} !== {3'b111, 20'd0}) begin
      bad++;
      $display("FAIL first_pos got=%b%b%b x=%0d y=%0d required=111 x=0 y=0",
               ls[0], fs[0], de[0], px[0], py[0]);
    end
  endtask

  task automatic test_horizontal();
    int c = 0, t = 0, de_cnt = 1, hs_cnt = 0, hs_first = -1;
    bit seen = 0;
    while (c < 3300 && !seen) begin
      @(negedge clk);
      c++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++;
          $display("FAIL model[%0d] at %0t got=%h required=%h", k, $time, obs_of(k), exp_of(k));
        end
      end
      if (tick[0]) begin
        t++;
        if (ls[0]) begin
          seen = 1;
        end else begin
          if (de[0]) de_cnt++;
          if (hs[0] === 1'b0) begin
            if (hs_first < 0) hs_first = t;
            hs_cnt++;
          end
        end
      end
    end
    total++;
    if (!seen || c != 3200) begin
      bad++;
      $display("FAIL line_period got=%0d clocks (seen=%0d) required=3200", c, seen);
    end
    total++;
    if (t != 800) begin
      bad++;
      $display("FAIL line_ticks got=%0d required=800", t);
    end
    total++;
    if (de_cnt != 640) begin
      bad++;
      $display("FAIL active_ticks got=%0d required=640", de_cnt);
    end
    total++;
    if (hs_cnt != 96 || hs_first != 656) begin
      bad++;
      $display("FAIL hsync_window got=%0d@%0d required=96@656", hs_cnt, hs_first);
    end
    total++;
    if (py[0] !== 10'd1) begin
      bad++;
      $display("FAIL next_line_y got=%0d required=1", py[0]);
    end
  endtask

  task automatic test_vertical();
    int c = 0, t = 0, vs_cnt = 0;
    bit got = 0;
    while (c < 500 && !got) begin
      @(negedge clk);
      c++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++;
          $display("FAIL model[%0d] at %0t got=%h required=%h", k, $time, obs_of(k), exp_of(k));
        end
      end
      if (fs[1]) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL frame_wait got=none required=frameStart within 500 clocks");
    end
    total++;
    if (ls[1] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_line got=%b required=1", ls[1]);
    end
    got = 0;
    c = 0;
    while (c < 500 && !got) begin
      @(negedge clk);
      c++;
      if (tick[1]) begin
        t++;
        if (fs[1]) begin
          got = 1;
        end else begin
          total++;
          if ((vs[1] === 1'b0) !== ((t / 14) == 5)) begin
            bad++;
            $display("FAIL vsync_line tick=%0d got=%b required_low=%0d", t, vs[1], (t / 14) == 5);
          end
          if (vs[1] === 1'b0) vs_cnt++;
          total++;
          if (de[1] !== 1'b0 && (t / 14) >= 4) begin
            bad++;
            $display("FAIL blank_active tick=%0d got=%b required=0", t, de[1]);
          end
        end
      end
    end
    total++;
    if (!got || t != 98) begin
      bad++;
      $display("FAIL frame_period got=%0d ticks required=98", t);
    end
    total++;
    if (vs_cnt != 14) begin
      bad++;
      $display("FAIL vsync_width got=%0d required=14", vs_cnt);
    end
  endtask

  task automatic test_enable();
    logic [25:0] mask, save;
    int ph, c;
    bit got;
    mask = {1'b0, 3'b111, 2'b00, 20'hFFFFF};
    c = 0;
    got = 0;
    while (c < 8 && !got) begin
      @(negedge clk);
      c++;
      got = tick[0];
    end
    ph = $urandom_range(0, 3);
    repeat (ph) @(negedge clk);
    save = obs_of(0) & mask;
    enable = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (tick[k] !== 1'b0 || ls[k] !== 1'b0 || fs[k] !== 1'b0) begin
          bad++;
          $display("FAIL gap_strobe[%0d] got=%b%b%b required=000", k, tick[k], ls[k], fs[k]);
        end
      end
      total++;
      if ((obs_of(0) & mask) !== save) begin
        bad++;
        $display("FAIL gap_hold got=%h required=%h", obs_of(0) & mask, save);
      end
    end
    enable = 1'b1;
    c = 0;
    got = 0;
    while (c < 8 && !got) begin
      @(negedge clk);
      c++;
      got = tick[0];
    end
    total++;
    if (!got || c != 4 - ph) begin
      bad++;
      $display("FAIL resume_phase got=%0d clocks required=%0d", c, 4 - ph);
    end
  endtask

  task automatic test_midreset();
    int c = 0;
    bit got = 0;
    logic [25:0] rv;
    while (c < 6000 && !got) begin
      @(negedge clk);
      c++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++;
          $display("FAIL model[%0d] at %0t got=%h required=%h", k, $time, obs_of(k), exp_of(k));
        end
      end
      got = tick[0] && px[0] == 10'd400 && py[0] == 10'd1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL reach_400_1 got=x%0d y%0d required=x400 y1", px[0], py[0]);
    end
    res = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      rv = {1'b0, (p_pol[k] == 0), (p_pol[k] == 0), 23'd0};
      total++;
      if (obs_of(k) !== rv) begin
        bad++;
        $display("FAIL async_reset[%0d] got=%h required=%h", k, obs_of(k), rv);
      end
    end
    repeat (2) @(negedge clk);
    res = 1'b0;
    c = 0;
    got = 0;
    while (c < 8 && !got) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        total++;
        if (fs[2] !== 1'b1) begin
          bad++;
          $display("FAIL fast_restart got=%b required=1", fs[2]);
        end
      end
      got = fs[0];
    end
    total++;
    if (!got || c != 4 || fs[1] !== 1'b1) begin
      bad++;
      $display("FAIL restart_frame got=%0d clocks small=%b required=4 clocks small=1", c, fs[1]);
    end
  endtask

  task automatic test_fast();
    int c = 0, t = 0, hs_cnt = 0, hs_first = -1;
    bit got = 0;
    while (c < 900 && !got) begin
      @(negedge clk);
      c++;
      got = ls[2];
    end
    got = 0;
    c = 0;
    while (c < 900 && !got) begin
      @(negedge clk);
      c++;
      total++;
      if (tick[2] !== 1'b1 || vs[2] !== 1'b0) begin
        bad++;
        $display("FAIL fast_tick_vs clk=%0d got=%b%b required=10", c, tick[2], vs[2]);
      end
      t++;
      if (ls[2]) begin
        got = 1;
      end else if (hs[2] === 1'b1) begin
        if (hs_first < 0) hs_first = t;
        hs_cnt++;
      end
    end
    total++;
    if (!got || c != 800 || hs_cnt != 96 || hs_first != 656) begin
      bad++;
      $display("FAIL fast_line got=%0d clk hs=%0d@%0d required=800 clk hs=96@656", c, hs_cnt, hs_first);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++;
          $display("FAIL model[%0d] at %0t got=%h required=%h", k, $time, obs_of(k), exp_of(k));
        end
      end
      enable = ($urandom % 4) != 0;
    end
    enable = 1'b1;
  endtask

  initial begin
    res = 1'b1;
    enable = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_enable();
    test_midreset();
    test_fast();
    test_random_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
